// File: rtl/mag_compare_seq.sv
// Sequential byte-serial magnitude comparator: one byte per cycle, LSB first.
// Define MAG_COMPARE_SEQ_SIGNED_EN to compare operands as two's complement.
module mag_compare_seq #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] a_in,
  input  logic [8*BYTES-1:0] b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               alb,
  output logic               agb,
  output logic               aeb
);

  localparam int W = 8 * BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [2:0]   idx, idx_nxt;
  logic [W-1:0] a_reg, b_reg, a_nxt, b_nxt;
  logic [2:0]   flags_nxt;
  logic [7:0]   a_byte, b_byte;
  logic         last_byte;

  function automatic logic [7:0] pick_byte(input logic [W-1:0] op, input logic [2:0] i);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (int'(i) == k) r = op[8*k +: 8];
    end
    return r;
  endfunction

  // A later (more significant) byte that differs overrides any earlier verdict.
  function automatic logic [2:0] cascade(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] prev);
    logic [2:0] r;
    r = prev;
    if (a > b)      r = 3'b010;
    else if (a < b) r = 3'b100;
    return r;
  endfunction

  always_comb begin
    last_byte = (int'(idx) == BYTES - 1);
    a_byte    = pick_byte(a_reg, idx);
    b_byte    = pick_byte(b_reg, idx);
`ifdef MAG_COMPARE_SEQ_SIGNED_EN
    // Flipping the sign bits maps two's complement order onto unsigned order.
    a_byte[7] = a_byte[7] ^ last_byte;
    b_byte[7] = b_byte[7] ^ last_byte;
`endif
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    flags_nxt = {alb, agb, aeb};
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_nxt     = a_in;
          b_nxt     = b_in;
          idx_nxt   = 3'd0;
          flags_nxt = 3'b001;
          state_nxt = RUN;
        end
      end
      RUN: begin
        flags_nxt = cascade(a_byte, b_byte, {alb, agb, aeb});
        idx_nxt   = idx + 3'd1;
        if (last_byte) state_nxt = HOLD;
      end
      HOLD: begin
        // Returning to IDLE never captures in the same edge.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= 3'd0;
      a_reg           <= '0;
      b_reg           <= '0;
      {alb, agb, aeb} <= 3'b001;
    end else begin
      state           <= state_nxt;
      idx             <= idx_nxt;
      a_reg           <= a_nxt;
      b_reg           <= b_nxt;
      {alb, agb, aeb} <= flags_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

endmodule
